miriscv_data_mem_responder: RTL and testbench

- Data-memory slave that answers the core's data-memory interface, i.e. the far end of the `data_rvalid_i`/`data_rdata_i` pair consumed by the memory-plus stage.
- Accepts one load/store request at a time and applies byte enables on stores.
- Returns a full aligned 32-bit word with a one-cycle `data_rvalid_o` pulse after a configurable latency. Lane extraction and sign extension stay in the core.
- Used as the data RAM in the core testbench and in the FPGA top level.

---
 rtl/miriscv_data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_miriscv_data_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_data_mem_responder.sv
// Data-memory slave for the miriscv data interface: one request at a time,
// byte-enabled stores, full-word load data returned LATENCY cycles after
// acceptance as a single-cycle rvalid pulse. Lane extraction and sign
// extension are left to the core.
module miriscv_data_mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o,
  output logic            data_err_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   mem_q [MEM_WORDS];

  logic [IDX_W-1:0]  word_idx;
  logic              out_of_range;
  logic              accept;
  logic [1:0]        unused_addr_bits;

  // The two lowest address bits select a byte lane, which the core resolves.
  assign unused_addr_bits = data_addr_i[1:0];

  assign word_idx     = data_addr_i[IDX_W+1:2];
  assign out_of_range = |data_addr_i[XLEN-1:IDX_W+2];
  // A request arriving in the same cycle as reset is never taken.
  assign accept       = data_req_i & gnt_q & ~rst_i;

  // Byte-enabled store into the word array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && !out_of_range) begin
      for (int i = 0; i < XLEN / 8; i++) begin
        if (data_be_i[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Next-state logic: capture the response at acceptance, count down the
  // latency, and derive the registered interface outputs from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          resp_rdata_d = (data_we_i || out_of_range) ? '0 : mem_q[word_idx];
          resp_err_d   = out_of_range;
          cnt_d        = LAT_M1;
          state_d      = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    gnt_d    = (state_d != WAIT);
    rvalid_d = (state_d == RESP);
    rdata_d  = rvalid_d ? resp_rdata_d : '0;
    err_d    = rvalid_d ? resp_err_d : 1'b0;
  end

  // State and output registers with synchronous reset; a pending response is
  // simply discarded by returning to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      gnt_q        <= 1'b1;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign data_gnt_o    = gnt_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  // With a multi-cycle latency the single outstanding request makes
  // back-to-back response pulses impossible.
  rvalid_no_back_to_back: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (LATENCY > 1 && data_rvalid_o) |=> !data_rvalid_o
  );

endmodule

// File: tb/tb_miriscv_data_mem_responder.sv
// Directed bench for miriscv_data_mem_responder. Four instances with
// latencies 2, 1, 4 and 3 share one clock; expected responses are queued when
// a request is driven and checked when rvalid appears.
module tb_miriscv_data_mem_responder;

  localparam int N = 4;

  logic        clk;
  logic        rst    [N];
  logic        req    [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];

  int cycle = 0;
  int asserts = 0;
  int failures = 0;
  bit monOn = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count; a response is due on the cycle value it
  // carries when sampled on the falling edge.
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3;
    miriscv_data_mem_responder #(
      .XLEN(32),
      .MEM_WORDS(1024),
      .LATENCY(LAT)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst[g]),
      .data_req_i   (req[g]),
      .data_we_i    (we[g]),
      .data_be_i    (be[g]),
      .data_addr_i  (addr[g]),
      .data_wdata_i (wdata[g]),
      .data_gnt_o   (gnt[g]),
      .data_rvalid_o(rvalid[g]),
      .data_rdata_o (rdata[g]),
      .data_err_o   (err[g])
    );
  end

  function automatic int latOf(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle on instance k; the caller ensures
  // the instance is able to grant. The expected response is queued with its
  // due cycle unless the request is meant to be cut by reset.
  task automatic applyStimulus(input int k, input bit w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expRd, input logic expErr,
                               input bit push);
    exp_t e;
    checkBit($sformatf("gnt_before_req_i%0d_a%h", k, a), gnt[k], 1'b1);
    req[k]   = 1'b1;
    we[k]    = w;
    be[k]    = b;
    addr[k]  = a;
    wdata[k] = d;
    if (push) begin
      e.inst  = k;
      e.rdata = expRd;
      e.err   = expErr;
      e.due   = cycle + latOf(k);
      sbq.push_back(e);
    end
    @(negedge clk);
    #1;
    req[k] = 1'b0;
  endtask

  // Bounded wait until every queued response has been seen.
  task automatic waitDrain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("drain_%s", tag), 32'(sbq.size()), 32'd0);
  endtask

  // Response monitor: every rvalid must match the head of the scoreboard on
  // the right instance and cycle; outside a response the data lines are 0.
  always @(negedge clk) begin
    exp_t e;
    if (monOn) begin
      for (int k = 0; k < N; k++) begin
        if (rvalid[k] === 1'b1) begin
          checkBit($sformatf("rvalid_expected_i%0d", k),
                   (sbq.size() != 0) && (sbq.size() != 0 ? sbq[0].inst == k : 1'b0), 1'b1);
          if (sbq.size() != 0 && sbq[0].inst == k) begin
            e = sbq.pop_front();
            checkOutput($sformatf("rdata_i%0d", k), rdata[k], e.rdata);
            checkBit($sformatf("err_i%0d", k), err[k], e.err);
            checkOutput($sformatf("resp_cycle_i%0d", k), 32'(cycle), 32'(e.due));
          end
        end else begin
          checkOutput($sformatf("idle_rdata_i%0d", k), rdata[k], 32'd0);
          checkBit($sformatf("idle_err_i%0d", k), err[k], 1'b0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: bench did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int last;
    bit first;
    logic expG;

    for (int k = 0; k < N; k++) begin
      rst[k]   = 1'b1;
      req[k]   = 1'b0;
      we[k]    = 1'b0;
      be[k]    = 4'h0;
      addr[k]  = '0;
      wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checkBit($sformatf("reset_gnt_i%0d", k), gnt[k], 1'b1);
      checkBit($sformatf("reset_rvalid_i%0d", k), rvalid[k], 1'b0);
      checkOutput($sformatf("reset_rdata_i%0d", k), rdata[k], 32'd0);
      checkBit($sformatf("reset_err_i%0d", k), err[k], 1'b0);
      rst[k] = 1'b0;
    end
    monOn = 1'b1;
    @(negedge clk);
    #1;

    // Instance 0, latency 2: full store, wait-state grant, load back.
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    checkBit("wait_gnt_low", gnt[0], 1'b0);
    waitDrain("st10");
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    waitDrain("ld10");

    // Single byte lane, then an all-disabled store.
    applyStimulus(0, 1'b1, 4'b0100, 32'h12, 32'h00AA0000, 32'h0, 1'b0, 1'b1);
    waitDrain("st12");
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1);
    waitDrain("ld10_be");
    applyStimulus(0, 1'b1, 4'b0000, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b1);
    waitDrain("st10_be0");
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1);
    waitDrain("ld10_be0");

    // Out of range: first byte past the array, plus the last in-range word.
    applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'h11112222, 32'h0, 1'b0, 1'b1);
    waitDrain("st0");
    applyStimulus(0, 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1);
    waitDrain("ld_oor");
    applyStimulus(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    waitDrain("st_oor");
    applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11112222, 1'b0, 1'b1);
    waitDrain("ld0_after_oor");
    applyStimulus(0, 1'b1, 4'hF, 32'hFFC, 32'hA5A5C3C3, 32'h0, 1'b0, 1'b1);
    waitDrain("st_top");
    applyStimulus(0, 1'b0, 4'h0, 32'hFFC, 32'h0, 32'hA5A5C3C3, 1'b0, 1'b1);
    waitDrain("ld_top");

    // Instance 1, latency 1: back-to-back stores and streaming loads.
    applyStimulus(1, 1'b1, 4'hF, 32'h0, 32'd1, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'h4, 32'd2, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'h8, 32'd3, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 32'h4, 32'h0, 32'd2, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 32'h8, 32'h0, 32'd3, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 4'hF, 32'hC, 32'h5566_7788, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 32'hC, 32'h0, 32'h5566_7788, 1'b0, 1'b1);
    waitDrain("stream");

    // Instance 2, latency 4: a load cut by reset never responds.
    applyStimulus(2, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    waitDrain("st20");
    applyStimulus(2, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    checkBit("cut_wait_gnt_low", gnt[2], 1'b0);
    rst[2] = 1'b1;
    @(negedge clk);
    #1;
    rst[2] = 1'b0;
    checkBit("gnt_after_reset", gnt[2], 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkBit($sformatf("no_rvalid_after_cut_%0d", i), rvalid[2], 1'b0);
      @(negedge clk);
      #1;
    end
    applyStimulus(2, 1'b0, 4'h0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    waitDrain("ld20_after_reset");

    // Instance 3, latency 3: request held high, grants only outside WAIT.
    applyStimulus(3, 1'b1, 4'hF, 32'h30, 32'h3030_3030, 32'h0, 1'b0, 1'b1);
    waitDrain("st30");
    last  = -1000;
    first = 1'b1;
    req[3]  = 1'b1;
    we[3]   = 1'b0;
    be[3]   = 4'h0;
    addr[3] = 32'h30;
    for (int i = 0; i < 13; i++) begin
      exp_t e;
      expG = first || ((cycle - last) == latOf(3) - 1);
      checkBit($sformatf("held_gnt_%0d", i), gnt[3], expG);
      if (expG) begin
        e.inst  = 3;
        e.rdata = 32'h3030_3030;
        e.err   = 1'b0;
        e.due   = cycle + latOf(3);
        sbq.push_back(e);
        last  = cycle + 1;
        first = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    req[3] = 1'b0;
    waitDrain("held");

    repeat (6) @(negedge clk);
    #1;
    checkOutput("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
